// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
module uart_tx_mmio #(
   parameter int          FIFO_DEPTH_BITS = 4,
   parameter logic [15:0] DEFAULT_DIVISOR = 16'd16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        write,
   input  logic        read,
   input  logic [3:0]  address,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        tx,
   output logic        irq_empty
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_BITS{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   count;
   logic                       overflow;
   logic [15:0]                divisor;
   logic [15:0]                cur_div;
   logic [15:0]                baud_cnt;
   logic [1:0]                 state;
   logic [2:0]                 bit_idx;
   logic [7:0]                 shift;

   logic        sel_data;
   logic        sel_status;
   logic        sel_div;
   logic        empty;
   logic        full;
   logic        busy;
   logic        push_req;
   logic        push;
   logic        pop;
   logic        drop;
   logic        bit_done;
   logic [15:0] div_eff;
   logic [31:0] status;

   assign sel_data   = (address[3:2] == 2'd0);
   assign sel_status = (address[3:2] == 2'd1);
   assign sel_div    = (address[3:2] == 2'd2);

   assign empty     = (count == '0);
   assign full      = (count == FULL_COUNT);
   assign busy      = (state != S_IDLE);
   assign irq_empty = empty && !busy;

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign pop      = !busy && !empty;
   assign push_req = write && sel_data;
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   assign div_eff  = (divisor == 16'd0) ? 16'd1 : divisor;
   assign bit_done = (baud_cnt == cur_div - 16'd1);

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= data_in[7:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (write && sel_status)
            overflow <= 1'b0;
         else if (drop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         divisor <= DEFAULT_DIVISOR;
      else if (write && sel_div)
         divisor <= data_in[15:0];
   end

   // cur_div is reloaded at every bit boundary so divisor changes take effect on the next bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cur_div  <= 16'd1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  baud_cnt <= '0;
                  cur_div  <= div_eff;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  cur_div  <= div_eff;
                  bit_idx  <= '0;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  cur_div  <= div_eff;
                  shift    <= {1'b0, shift[7:1]};
                  bit_idx  <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  state    <= S_IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // The line register follows the state one clock later, which keeps every bit exactly cur_div wide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         tx <= 1'b1;
      else begin
         case (state)
            S_START: tx <= 1'b0;
            S_DATA:  tx <= shift[0];
            default: tx <= 1'b1;
         endcase
      end
   end

   always_comb begin
      status = '0;
      status[0] = busy;
      status[1] = full;
      status[2] = empty;
      status[3] = overflow;
      status[8 +: FIFO_DEPTH_BITS+1] = count;
   end

   always_comb begin
      data_out = '0;
      if (read) begin
         if (sel_status)
            data_out = status;
         else if (sel_div)
            data_out = {16'd0, divisor};
      end
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        write = 1'b0;
   logic        read  = 1'b0;
   logic [3:0]  address = '0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        tx;
   logic        irq_empty;

   uart_tx_mmio dut (
      .clock     (clock),
      .reset     (reset),
      .write     (write),
      .read      (read),
      .address   (address),
      .data_in   (data_in),
      .data_out  (data_out),
      .tx        (tx),
      .irq_empty (irq_empty)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Serial line receiver: samples every clock of every bit and flags any bit that is not constant.
   bit         mon_en   = 1'b0;
   int         mon_div  = 1;
   bit         mon_busy = 1'b0;
   int         frame_err = 0;
   logic [7:0] rx_q[$];
   int         start_q[$];
   logic [9:0] mf;
   bit         mbad;
   int         md;

   initial forever begin
      @(negedge clock);
      if (mon_en && tx === 1'b0) begin
         mon_busy = 1'b1;
         md = mon_div;
         mbad = 1'b0;
         start_q.push_back(cyc);
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < md; j++) begin
               if (k != 0 || j != 0) @(negedge clock);
               if (j == 0) mf[k] = tx;
               else if (tx !== mf[k]) mbad = 1'b1;
            end
         end
         if (mbad || mf[0] !== 1'b0 || mf[9] !== 1'b1) frame_err++;
         rx_q.push_back(mf[8:1]);
         mon_busy = 1'b0;
      end
   end

   typedef struct {
      logic        w;
      logic        r;
      logic [3:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic bus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] q);
      @(negedge clock);
      write = w; read = r; address = a; data_in = d;
      #1 q = data_out;
      @(posedge clock);
      #1 write = 1'b0; read = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, 1'b0, a, d, dummy);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] q);
      bus(1'b0, 1'b1, a, 32'd0, q);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic clear_rx();
      rx_q.delete();
      start_q.delete();
      frame_err = 0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(irq_empty && !mon_busy) && n < 5000) begin
         @(posedge clock);
         n++;
      end
      repeat (3) @(posedge clock);
      chk("drain_in_time", (n < 5000), 1);
   endtask

   task automatic chk_rx(input string nm, input logic [7:0] exp);
      logic [7:0] v;
      if (rx_q.size() > 0) v = rx_q.pop_front();
      else v = 'x;
      chk(nm, v, exp);
   endtask

   logic [31:0] q;
   logic [7:0]  model[$];
   int          push_cyc;
   int          lows;

   initial begin
      tbl[0]  = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h0000_0004};
      tbl[1]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'h0000_0010};
      tbl[2]  = '{1'b1, 1'b0, 4'h8, 32'hABCD_1234, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'h0000_1234};
      tbl[4]  = '{1'b0, 1'b1, 4'h0, 32'h0,        32'h0};
      tbl[5]  = '{1'b1, 1'b1, 4'hC, 32'hFFFF,     32'h0};
      tbl[6]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'h0000_1234};
      tbl[7]  = '{1'b1, 1'b1, 4'h8, 32'h7,        32'h0000_1234};
      tbl[8]  = '{1'b0, 1'b1, 4'h8, 32'h0,        32'h0000_0007};
      tbl[9]  = '{1'b0, 1'b1, 4'h9, 32'h0,        32'h0000_0007};
      tbl[10] = '{1'b1, 1'b0, 4'h4, 32'hFFFF_FFFF, 32'h0};
      tbl[11] = '{1'b0, 1'b1, 4'h4, 32'h0,        32'h0000_0004};

      do_reset();
      chk("reset_tx", tx, 1);
      chk("reset_irq_empty", irq_empty, 1);
      chk("reset_data_out", data_out, 0);
      for (int i = 0; i < 12; i++) begin
         bus(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, q);
         chk($sformatf("regvec%0d", i), q, tbl[i].exp);
      end

      // single frame, div=4
      do_reset();
      mon_en = 1'b1; mon_div = 4;
      wr(4'h8, 32'd4);
      clear_rx();
      wr(4'h0, 32'h55);
      push_cyc = cyc;
      wait_drain();
      chk("f55_count", rx_q.size(), 1);
      chk("f55_start_latency", (start_q.size() > 0) ? start_q[0] - push_cyc : -1, 2);
      chk_rx("f55_byte", 8'h55);
      chk("f55_frame_ok", frame_err, 0);
      rd(4'h4, q);
      chk("f55_status_idle", q, 32'h4);

      // back-to-back frames, div=2
      do_reset();
      mon_div = 2;
      wr(4'h8, 32'd2);
      clear_rx();
      wr(4'h0, 32'hA3);
      wr(4'h0, 32'h5C);
      begin
         int n = 0;
         while (start_q.size() < 2 && n < 200) begin @(posedge clock); n++; end
      end
      repeat (4) @(posedge clock);
      #1 chk("b2b_irq_low_mid", irq_empty, 0);
      wait_drain();
      chk("b2b_gap", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 21);
      chk_rx("b2b_first", 8'hA3);
      chk_rx("b2b_second", 8'h5C);
      chk("b2b_frame_ok", frame_err, 0);
      chk("b2b_irq_high_after", irq_empty, 1);

      // divisor 0 behaves as 1
      do_reset();
      mon_div = 1;
      wr(4'h8, 32'd0);
      rd(4'h8, q);
      chk("div0_readback", q, 0);
      clear_rx();
      wr(4'h0, 32'hFF);
      wr(4'h0, 32'h00);
      wait_drain();
      chk("div0_gap", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, 11);
      chk_rx("div0_first", 8'hFF);
      chk_rx("div0_second", 8'h00);
      chk("div0_frame_ok", frame_err, 0);

      // fill, full and overflow, div=100
      do_reset();
      mon_en = 1'b0;
      wr(4'h8, 32'd100);
      for (int i = 0; i < 16; i++) wr(4'h0, i);
      rd(4'h4, q);
      chk("fill_status15", q, 32'h0F01);
      wr(4'h0, 32'h10);
      rd(4'h4, q);
      chk("fill_status_full", q, 32'h1003);
      wr(4'h0, 32'h11);
      rd(4'h4, q);
      chk("fill_overflow_set", q, 32'h100B);
      wr(4'h4, 32'h0);
      rd(4'h4, q);
      chk("fill_overflow_clear", q, 32'h1003);

      // push into full FIFO in the cycle the FSM pops
      do_reset();
      mon_en = 1'b1; mon_div = 2;
      wr(4'h8, 32'd2);
      clear_rx();
      model.delete();
      for (int i = 0; i <= 16; i++) begin
         wr(4'h0, 32'h20 + i);
         model.push_back(8'(32'h20 + i));
      end
      rd(4'h4, q);
      chk("popfull_before", q, 32'h1003);
      repeat (4) @(posedge clock);
      wr(4'h0, 32'h77);
      model.push_back(8'h77);
      rd(4'h4, q);
      chk("popfull_after_no_ovf", q, 32'h1003);
      wait_drain();
      chk("popfull_count", rx_q.size(), model.size());
      while (model.size() > 0) chk_rx("popfull_byte", model.pop_front());
      chk("popfull_frame_ok", frame_err, 0);

      // reset in the middle of bit 3
      do_reset();
      mon_en = 1'b0;
      wr(4'h8, 32'd4);
      wr(4'h0, 32'hF7);
      wr(4'h0, 32'h01);
      wr(4'h0, 32'h02);
      repeat (16) @(posedge clock);
      @(negedge clock);
      chk("midrst_bit3_low", tx, 0);
      reset = 1'b0;
      #1 chk("midrst_tx_high", tx, 1);
      chk("midrst_irq", irq_empty, 1);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      rd(4'h4, q);
      chk("midrst_status", q, 32'h4);
      lows = 0;
      repeat (200) begin
         @(negedge clock);
         if (tx !== 1'b1) lows++;
      end
      chk("midrst_no_frames", lows, 0);

      // randomized traffic against a byte-order model
      do_reset();
      mon_en = 1'b1;
      for (int round = 0; round < 4; round++) begin
         int d;
         int n;
         d = $urandom_range(1, 4);
         mon_div = d;
         wr(4'h8, d);
         clear_rx();
         model.delete();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            wr(4'h0, {24'd0, b});
            model.push_back(b);
            repeat ($urandom_range(0, 3)) @(posedge clock);
         end
         wait_drain();
         chk($sformatf("rand%0d_count", round), rx_q.size(), model.size());
         while (model.size() > 0) chk_rx($sformatf("rand%0d_byte", round), model.pop_front());
         chk($sformatf("rand%0d_frame_ok", round), frame_err, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
